// File: rtl/ms_countdown_timer.sv
// Loadable millisecond countdown driven by the 1 ms tick. Provides busy/paused
// levels, a one-cycle done pulse on expiry, pause, abort, retrigger and
// optional periodic auto-reload.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | no interval active; ticks ignored, remaining is 0
//   ST_RUN    | counting down; each tick decrements remaining
//   ST_PAUSED | interval suspended; ticks ignored, remaining held
module ms_countdown_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1ms,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             periodic,
  output logic             busy,
  output logic             paused,
  output logic [WIDTH-1:0] remaining,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;
  logic             done_q, done_d;

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      reload_q    <= '0;
      periodic_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      periodic_q  <= periodic_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic, priority abort > start > pause > tick.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    periodic_d  = periodic_q;
    done_d      = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
    end else if (start) begin
      if (load_val != '0) begin
        // Fresh load or retrigger: any tick this cycle is discarded.
        state_d     = ST_RUN;
        remaining_d = load_val;
        reload_d    = load_val;
        periodic_d  = periodic;
      end else begin
        // Zero-length request expires immediately and cancels any interval.
        state_d     = ST_IDLE;
        remaining_d = '0;
        done_d      = 1'b1;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (tick_1ms) begin
            if (remaining_q > WIDTH'(1)) begin
              remaining_d = remaining_q - WIDTH'(1);
            end else if (remaining_q == WIDTH'(1)) begin
              done_d = 1'b1;
              if (periodic_q) begin
                remaining_d = reload_q;
              end else begin
                remaining_d = '0;
                state_d     = ST_IDLE;
              end
            end
          end
        end
        ST_PAUSED: begin
          // The resume cycle itself does not consume a tick.
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    busy      = (state_q == ST_RUN) || (state_q == ST_PAUSED);
    paused    = (state_q == ST_PAUSED);
    remaining = remaining_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_ms_countdown_timer.sv
// Bench for ms_countdown_timer: directed scenarios followed by random traffic,
// every cycle compared against an integer-level model of the timer.
module tb_ms_countdown_timer;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             tick_1ms;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             abort;
  logic             periodic;
  logic             busy;
  logic             paused;
  logic [WIDTH-1:0] remaining;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: an interval is either inactive, counting, or suspended.
  bit m_active;
  bit m_susp;
  int m_left;
  int m_reload;
  bit m_repeat;
  bit m_done;

  ms_countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1ms  (tick_1ms),
    .load_val  (load_val),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .periodic  (periodic),
    .busy      (busy),
    .paused    (paused),
    .remaining (remaining),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_susp   = 0;
    m_left   = 0;
    m_reload = 0;
    m_repeat = 0;
    m_done   = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    m_done = 0;
    if (abort) begin
      m_active = 0;
      m_susp   = 0;
      m_left   = 0;
    end else if (start) begin
      if (int'(load_val) != 0) begin
        m_active = 1;
        m_susp   = 0;
        m_left   = int'(load_val);
        m_reload = int'(load_val);
        m_repeat = periodic;
      end else begin
        m_active = 0;
        m_susp   = 0;
        m_left   = 0;
        m_done   = 1;
      end
    end else if (m_active && !m_susp) begin
      if (pause) begin
        m_susp = 1;
      end else if (tick_1ms && m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_done = 1;
          if (m_repeat) m_left = m_reload;
          else m_active = 0;
        end
      end
    end else if (m_active && m_susp) begin
      if (!pause) m_susp = 0;
    end
  endtask

  task automatic check_outputs();
    chk("busy", busy, m_active);
    chk("paused", paused, m_active && m_susp);
    chk("remaining", remaining, m_left);
    chk("done", done, m_done);
  endtask

  // One clock: inputs are set at the falling edge, checked 1 ns after rising edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    start    = 1'b0;
    abort    = 1'b0;
    tick_1ms = 1'b0;
  endtask

  task automatic do_start(input int lv, input bit per);
    start    = 1'b1;
    load_val = WIDTH'(lv);
    periodic = per;
    cyc();
  endtask

  task automatic do_ticks(input int n, input int spacing);
    for (int i = 0; i < n; i++) begin
      tick_1ms = 1'b1;
      cyc();
      for (int j = 1; j < spacing; j++) cyc();
    end
  endtask

  initial begin
    rst      = 1'b1;
    tick_1ms = 1'b0;
    load_val = '0;
    start    = 1'b0;
    pause    = 1'b0;
    abort    = 1'b0;
    periodic = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of an interval.
    do_start(5, 0);
    do_ticks(2, 2);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // One-shot, ticks spaced 10 clocks.
    do_start(3, 0);
    do_ticks(3, 10);

    // Periodic reload, then abort.
    do_start(2, 1);
    do_ticks(6, 3);
    abort = 1'b1;
    cyc();
    do_ticks(3, 2);

    // Pause holds the count; resume then expire.
    do_start(4, 0);
    do_ticks(1, 2);
    pause = 1'b1;
    cyc();
    do_ticks(5, 2);
    pause = 1'b0;
    tick_1ms = 1'b1;
    cyc();
    do_ticks(3, 2);

    // Retrigger colliding with a tick, then abort colliding with start.
    do_start(5, 0);
    do_ticks(2, 2);
    tick_1ms = 1'b1;
    do_start(7, 0);
    cyc();
    abort = 1'b1;
    do_start(9, 0);
    cyc();

    // Zero load cancels a running interval with an immediate done.
    do_start(5, 0);
    do_ticks(1, 2);
    do_start(0, 0);
    cyc();

    // Largest load value.
    do_start((1 << WIDTH) - 1, 0);
    do_ticks(2, 1);
    abort = 1'b1;
    cyc();

    // Random traffic.
    for (int k = 0; k < 4000; k++) begin
      abort    = ($urandom_range(0, 99) < 2);
      start    = ($urandom_range(0, 99) < 6);
      tick_1ms = ($urandom_range(0, 99) < 35);
      periodic = $urandom_range(0, 1);
      if ($urandom_range(0, 99) < 5) pause = ~pause;
      if ($urandom_range(0, 49) == 0) load_val = '1;
      else load_val = WIDTH'($urandom_range(0, 6));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
